regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the core's single-write, two-read integer register file.
- Adds a configurable number of read ports, an asynchronous active-low reset, write-to-read bypass and a per-register busy scoreboard.
- Sits between decode/issue and writeback in the pipelined core:
  - issue reads operands and allocates its destination;
  - writeback writes the result and clears the busy bit.

Parameters:
- ADD_WIDTH, 5, register address width; the file holds 2**ADD_WIDTH registers.
- DATA_WIDTH, 32, register data width.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and is never busy.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*ADD_WIDTH  packed read addresses; port k occupies bits [k*ADD_WIDTH +: ADD_WIDTH].
- rd_data  out  NUM_RD*DATA_WIDTH  packed read data, same packing as rd_addr.
- rd_ready  out  NUM_RD  bit k = 1 when rd_data for port k is architecturally valid.
- alloc_en  in  1  issue request: mark alloc_addr busy.
- alloc_addr  in  ADD_WIDTH  destination register being allocated.
- alloc_stall  out  1  alloc_en is refused this cycle.
- wb_en  in  1  writeback strobe.
- wb_addr  in  ADD_WIDTH  writeback destination.
- wb_data  in  DATA_WIDTH  writeback value.
- flush  in  1  pipeline flush: clears all busy bits; register contents are kept.
- busy_cnt  out  ADD_WIDTH+1  number of registers currently busy.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - all registers are 0;
  - all busy bits are 0;
  - busy_cnt = 0;
  - while rst_n = 0, rd_ready is all ones and rd_data is all zeros.
  - Reset asserted mid-operation discards any pending allocation or writeback in that cycle.
- Write:
  - at posedge clk, if wb_en and NOT (ZERO_REG and wb_addr == 0), then reg[wb_addr] <= wb_data;
  - the same edge clears busy[wb_addr].
- Read, per port k, combinational with zero latency:
  - if ZERO_REG and addr == 0: data = 0, ready = 1.
  - else if wb_en and wb_addr == addr: data = wb_data, ready = 1 (bypass).
  - else: data = reg[addr], ready = ~busy[addr].
- Allocate:
  - alloc_stall = alloc_en and busy[alloc_addr] and NOT (wb_en and wb_addr == alloc_addr). A WAW hazard stalls unless it is resolved this cycle.
  - If alloc_en and not alloc_stall and the address is not a zero register, set busy[alloc_addr] at posedge.
  - Allocation to register 0 with ZERO_REG = 1 is accepted silently and has no effect.
- Simultaneous events on the same address:
  - wb and alloc to the same address in the same cycle: data is written and busy ends at 1 (the new allocation wins).
  - Reads in that cycle see the bypassed wb_data with ready = 1. The allocation takes effect from the next cycle.
- Flush:
  - at posedge, all busy bits are cleared;
  - flush takes priority over alloc in the same cycle (the allocation is dropped);
  - a wb in the same cycle still writes data.
- busy_cnt:
  - registered, equal to the popcount of busy after each edge;
  - it is updated incrementally by +1 (alloc only), -1 (wb clearing a busy register only), 0 (both or neither), or reset to 0 by flush;
  - it never wraps: the maximum value is 2**ADD_WIDTH - ZERO_REG.
- A wb to a register that is not busy is legal: data is written and busy_cnt is unchanged.

Decomposition:
- Package regfile_pkg holds:
  - default width constants;
  - a helper function for packing and unpacking port slices;
  - a typedef rd_sel_e (SEL_ZERO, SEL_BYPASS, SEL_ARRAY) for the read-mux select.
- One sub-module, regfile_rdport: the combinational per-port zero/bypass/array mux plus ready logic, instantiated NUM_RD times via generate.
- The storage array, the busy vector and busy_cnt live in the top module.

Test Plan:
- Reset, then read ports at addresses 6 and 7 -> rd_data = 0, rd_ready = 1; busy_cnt = 0.
- alloc x5, then wb x5 = 0xDEADBEEF two cycles later:
  - reads of x5 show ready = 0 during the two cycles in between;
  - in the wb cycle the read returns 0xDEADBEEF (bypass) with ready = 1;
  - busy_cnt goes 0 -> 1 -> 0.
- With x9 busy:
  - alloc x9 without wb -> alloc_stall = 1 and busy_cnt stays 1;
  - alloc x9 together with wb x9 = 0x12 -> no stall, x9 = 0x12, busy remains 1.
- wb x0 = 0xFFFFFFFF and alloc x0 -> x0 reads 0 with ready = 1; busy_cnt unchanged.
- Allocate x1..x4, then assert flush together with alloc x8 -> all ready = 1, busy_cnt = 0, x8 not busy.
- Assert rst_n low asynchronously mid-cycle after x3 = 0x55 -> rd_data for x3 is 0 immediately; busy_cnt = 0.
- With NUM_RD = 4, all ports read x3 = 0x55 -> all four ports return 0x55.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths, read-mux select encoding and port-slice helper for regfile_sb.
package regfile_pkg;

  localparam int unsigned DEF_ADD_WIDTH  = 5;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_NUM_RD     = 2;
  localparam int unsigned DEF_ZERO_REG   = 1;

  // Source of a read port's data.
  typedef enum logic [1:0] {
    SEL_ZERO   = 2'd0,
    SEL_BYPASS = 2'd1,
    SEL_ARRAY  = 2'd2
  } rd_sel_e;

  // Low bit of port 'port' inside a packed multi-port bus of 'width'-bit slices.
  function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: zero-register / writeback-bypass / array mux plus ready.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned ADD_WIDTH  = DEF_ADD_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ZERO_REG   = DEF_ZERO_REG
) (
  input  logic                  i_rst_n,
  input  logic [ADD_WIDTH-1:0]  i_addr,
  input  logic                  i_wb_en,
  input  logic [ADD_WIDTH-1:0]  i_wb_addr,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  input  logic [DATA_WIDTH-1:0] i_arr_data,
  input  logic                  i_busy,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_ready
);

  rd_sel_e w_sel;

  // Pick the data source; the zero register outranks a (discarded) write to it.
  always_comb begin
    w_sel = SEL_ARRAY;
    if ((ZERO_REG != 0) && (i_addr == '0)) begin
      w_sel = SEL_ZERO;
    end else if (i_wb_en && (i_wb_addr == i_addr)) begin
      w_sel = SEL_BYPASS;
    end
  end

  // Drive data/ready; during reset the port reads as a ready zero.
  always_comb begin
    o_data  = i_arr_data;
    o_ready = ~i_busy;
    if (!i_rst_n) begin
      o_data  = '0;
      o_ready = 1'b1;
    end else begin
      case (w_sel)
        SEL_ZERO: begin
          o_data  = '0;
          o_ready = 1'b1;
        end
        SEL_BYPASS: begin
          o_data  = i_wb_data;
          o_ready = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with writeback bypass and per-register busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned ADD_WIDTH  = DEF_ADD_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_RD     = DEF_NUM_RD,
  parameter int unsigned ZERO_REG   = DEF_ZERO_REG
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_RD*ADD_WIDTH-1:0]  rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_ready,
  input  logic                         alloc_en,
  input  logic [ADD_WIDTH-1:0]         alloc_addr,
  output logic                         alloc_stall,
  input  logic                         wb_en,
  input  logic [ADD_WIDTH-1:0]         wb_addr,
  input  logic [DATA_WIDTH-1:0]        wb_data,
  input  logic                         flush,
  output logic [ADD_WIDTH:0]           busy_cnt
);

  localparam int unsigned NREG = 1 << ADD_WIDTH;
  localparam int unsigned CW   = ADD_WIDTH + 1;

  logic [DATA_WIDTH-1:0] r_regs [NREG];
  logic [NREG-1:0]       r_busy;
  logic [CW-1:0]         r_busy_cnt;

  logic                  w_wb_zero;
  logic                  w_alloc_zero;
  logic                  w_alloc_stall;
  logic                  w_alloc_set;
  logic                  w_wb_clr;
  logic [NREG-1:0]       w_busy_nxt;
  logic [CW-1:0]         w_cnt_nxt;

  assign w_wb_zero     = (ZERO_REG != 0) && (wb_addr == '0);
  assign w_alloc_zero  = (ZERO_REG != 0) && (alloc_addr == '0);
  // WAW hazard stalls unless the same-cycle writeback retires the old producer.
  assign w_alloc_stall = alloc_en && r_busy[alloc_addr] && !(wb_en && (wb_addr == alloc_addr));
  assign w_alloc_set   = alloc_en && !w_alloc_stall && !w_alloc_zero && !flush;
  assign w_wb_clr      = wb_en && r_busy[wb_addr];

  assign alloc_stall = w_alloc_stall;
  assign busy_cnt    = r_busy_cnt;

  // Next busy vector: writeback clears, allocation sets (wins), flush clears all.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_en) begin
      w_busy_nxt[wb_addr] = 1'b0;
    end
    if (w_alloc_set) begin
      w_busy_nxt[alloc_addr] = 1'b1;
    end
    if (flush) begin
      w_busy_nxt = '0;
    end
  end

  // Incremental popcount of the busy vector.
  always_comb begin
    w_cnt_nxt = r_busy_cnt;
    if (flush) begin
      w_cnt_nxt = '0;
    end else begin
      case ({w_alloc_set, w_wb_clr})
        2'b10:   w_cnt_nxt = r_busy_cnt + CW'(1);
        2'b01:   w_cnt_nxt = r_busy_cnt - CW'(1);
        default: w_cnt_nxt = r_busy_cnt;
      endcase
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  // Register storage; writes to a hardwired zero register are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wb_en && !w_wb_zero) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // One read mux per port.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADD_WIDTH-1:0] w_addr;
    assign w_addr = rd_addr[slice_lo(k, ADD_WIDTH) +: ADD_WIDTH];

    regfile_rdport #(
      .ADD_WIDTH  (ADD_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ZERO_REG   (ZERO_REG)
    ) u_rdport (
      .i_rst_n    (rst_n),
      .i_addr     (w_addr),
      .i_wb_en    (wb_en),
      .i_wb_addr  (wb_addr),
      .i_wb_data  (wb_data),
      .i_arr_data (r_regs[w_addr]),
      .i_busy     (r_busy[w_addr]),
      .o_data     (rd_data[slice_lo(k, DATA_WIDTH) +: DATA_WIDTH]),
      .o_ready    (rd_ready[k])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (4 read ports).
module tb_regfile_sb;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 4;

  logic             clk;
  logic             rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_ready;
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;
  logic             alloc_stall;
  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [DW-1:0]    wb_data;
  logic             flush;
  logic [AW:0]      busy_cnt;

  int n_cmp;
  int n_err;

  regfile_sb #(
    .ADD_WIDTH  (AW),
    .DATA_WIDTH (DW),
    .NUM_RD     (NR),
    .ZERO_REG   (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .alloc_en    (alloc_en),
    .alloc_addr  (alloc_addr),
    .alloc_stall (alloc_stall),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .flush       (flush),
    .busy_cnt    (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [DW-1:0] rdd(input int k);
    return rd_data[k*DW +: DW];
  endfunction

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    rd_addr = {a3, a2, a1, a0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_en = 1'b0;
    wb_en    = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'hAAAA_5555;
    set_rd(5'd6, 5'd7, 5'd6, 5'd7);
    @(negedge clk);
    n_cmp++;
    if (rd_ready !== 4'hF) begin
      n_err++; $display("FAIL reset_ready: got %b expected %b", rd_ready, 4'hF);
    end
    n_cmp++;
    if (rd_data !== '0) begin
      n_err++; $display("FAIL reset_data: got %h expected 0", rd_data);
    end
    wb_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++;
    if (rdd(0) !== 32'h0 || rdd(1) !== 32'h0 || rd_ready[1:0] !== 2'b11) begin
      n_err++; $display("FAIL reset_read67: got %h/%h rdy %b expected 0/0 rdy 11", rdd(0), rdd(1), rd_ready[1:0]);
    end
    n_cmp++;
    if (busy_cnt !== 6'd0) begin
      n_err++; $display("FAIL reset_cnt: got %0d expected 0", busy_cnt);
    end
  endtask

  task automatic test_alloc_wb();
    tick();
    idle();
    alloc_en = 1'b1; alloc_addr = 5'd5;
    set_rd(5'd5, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    n_cmp++;
    if (busy_cnt !== 6'd0) begin
      n_err++; $display("FAIL aw_cnt0: got %0d expected 0", busy_cnt);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      alloc_en = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (rd_ready[0] !== 1'b0 || busy_cnt !== 6'd1) begin
        n_err++; $display("FAIL aw_busy%0d: got rdy %b cnt %0d expected rdy 0 cnt 1", c, rd_ready[0], busy_cnt);
      end
    end
    tick();
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++;
    if (rdd(0) !== 32'hDEAD_BEEF || rd_ready[0] !== 1'b1) begin
      n_err++; $display("FAIL aw_bypass: got %h rdy %b expected deadbeef rdy 1", rdd(0), rd_ready[0]);
    end
    n_cmp++;
    if (busy_cnt !== 6'd1) begin
      n_err++; $display("FAIL aw_cnt_wb: got %0d expected 1", busy_cnt);
    end
    tick();
    wb_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rdd(0) !== 32'hDEAD_BEEF || rd_ready[0] !== 1'b1 || busy_cnt !== 6'd0) begin
      n_err++; $display("FAIL aw_after: got %h rdy %b cnt %0d expected deadbeef rdy 1 cnt 0", rdd(0), rd_ready[0], busy_cnt);
    end
  endtask

  task automatic test_waw();
    tick();
    idle();
    alloc_en = 1'b1; alloc_addr = 5'd9;
    set_rd(5'd9, 5'd0, 5'd0, 5'd0);
    tick();
    @(negedge clk);
    n_cmp++;
    if (alloc_stall !== 1'b1) begin
      n_err++; $display("FAIL waw_stall: got %b expected 1", alloc_stall);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (busy_cnt !== 6'd1) begin
      n_err++; $display("FAIL waw_cnt_stall: got %0d expected 1", busy_cnt);
    end
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h12;
    #1;
    n_cmp++;
    if (alloc_stall !== 1'b0 || rdd(0) !== 32'h12 || rd_ready[0] !== 1'b1) begin
      n_err++; $display("FAIL waw_resolve: got stall %b data %h rdy %b expected 0 12 1", alloc_stall, rdd(0), rd_ready[0]);
    end
    tick();
    idle();
    @(negedge clk);
    n_cmp++;
    if (rdd(0) !== 32'h12 || rd_ready[0] !== 1'b0 || busy_cnt !== 6'd1) begin
      n_err++; $display("FAIL waw_after: got %h rdy %b cnt %0d expected 12 rdy 0 cnt 1", rdd(0), rd_ready[0], busy_cnt);
    end
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h12;
    tick();
    idle();
    @(negedge clk);
    n_cmp++;
    if (busy_cnt !== 6'd0) begin
      n_err++; $display("FAIL waw_clear: got %0d expected 0", busy_cnt);
    end
  endtask

  task automatic test_zero_reg();
    tick();
    idle();
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    alloc_en = 1'b1; alloc_addr = 5'd0;
    set_rd(5'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    n_cmp++;
    if (rdd(0) !== 32'h0 || rd_ready[0] !== 1'b1 || alloc_stall !== 1'b0) begin
      n_err++; $display("FAIL zero_same: got %h rdy %b stall %b expected 0 1 0", rdd(0), rd_ready[0], alloc_stall);
    end
    tick();
    idle();
    @(negedge clk);
    n_cmp++;
    if (rdd(0) !== 32'h0 || rd_ready[0] !== 1'b1 || busy_cnt !== 6'd0) begin
      n_err++; $display("FAIL zero_after: got %h rdy %b cnt %0d expected 0 1 0", rdd(0), rd_ready[0], busy_cnt);
    end
  endtask

  task automatic test_flush();
    set_rd(5'd1, 5'd2, 5'd3, 5'd4);
    for (int r = 1; r <= 4; r++) begin
      tick();
      idle();
      alloc_en = 1'b1; alloc_addr = AW'(r);
    end
    tick();
    idle();
    @(negedge clk);
    n_cmp++;
    if (rd_ready !== 4'b0000 || busy_cnt !== 6'd4) begin
      n_err++; $display("FAIL flush_pre: got rdy %b cnt %0d expected 0000 cnt 4", rd_ready, busy_cnt);
    end
    flush = 1'b1;
    alloc_en = 1'b1; alloc_addr = 5'd8;
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'hAB;
    tick();
    idle();
    @(negedge clk);
    n_cmp++;
    if (rd_ready !== 4'b1111 || busy_cnt !== 6'd0) begin
      n_err++; $display("FAIL flush_post: got rdy %b cnt %0d expected 1111 cnt 0", rd_ready, busy_cnt);
    end
    n_cmp++;
    if (rdd(1) !== 32'hAB) begin
      n_err++; $display("FAIL flush_wb: got %h expected ab", rdd(1));
    end
    set_rd(5'd8, 5'd2, 5'd3, 5'd4);
    #1;
    n_cmp++;
    if (rd_ready[0] !== 1'b1) begin
      n_err++; $display("FAIL flush_x8: got rdy %b expected 1", rd_ready[0]);
    end
  endtask

  task automatic test_multi_port();
    tick();
    idle();
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h55;
    tick();
    idle();
    set_rd(5'd3, 5'd3, 5'd3, 5'd3);
    @(negedge clk);
    for (int k = 0; k < NR; k++) begin
      n_cmp++;
      if (rdd(k) !== 32'h55 || rd_ready[k] !== 1'b1) begin
        n_err++; $display("FAIL multi_port%0d: got %h rdy %b expected 55 rdy 1", k, rdd(k), rd_ready[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    tick();
    idle();
    alloc_en = 1'b1; alloc_addr = 5'd7;
    tick();
    idle();
    set_rd(5'd3, 5'd7, 5'd3, 5'd3);
    @(negedge clk);
    n_cmp++;
    if (busy_cnt !== 6'd1 || rdd(0) !== 32'h55) begin
      n_err++; $display("FAIL ares_pre: got cnt %0d data %h expected 1 55", busy_cnt, rdd(0));
    end
    #2;
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h99;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rdd(0) !== 32'h0 || rd_ready !== 4'hF || busy_cnt !== 6'd0) begin
      n_err++; $display("FAIL ares_now: got %h rdy %b cnt %0d expected 0 1111 0", rdd(0), rd_ready, busy_cnt);
    end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++;
    if (rdd(0) !== 32'h0 || rd_ready[1] !== 1'b1 || busy_cnt !== 6'd0) begin
      n_err++; $display("FAIL ares_after: got %h rdy7 %b cnt %0d expected 0 1 0", rdd(0), rd_ready[1], busy_cnt);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    rd_addr = '0;
    alloc_en = 1'b0; alloc_addr = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    flush = 1'b0;
    test_reset();
    test_alloc_wb();
    test_waw();
    test_zero_reg();
    test_flush();
    test_multi_port();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
